// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing instruction RAM and gating CPU reset
module prog_loader #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
    parameter int                MAX_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [4:0]        loaded_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COUNT  = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [DATA_W-1:0] MAX_B = DATA_W'(MAX_WORDS);

    state_t              state_q, state_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [4:0]          loaded_count_q, loaded_count_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [4:0]          remaining_q, remaining_d;
    logic                match_q, match_d;
    logic                accept;

    assign in_ready     = (state_q != ST_VERIFY);
    assign accept       = in_valid && in_ready;
    assign load_busy    = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                          (state_q == ST_CHECK) || (state_q == ST_VERIFY);
    assign cpu_rst_n    = cpu_rst_n_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign loaded_count = loaded_count_q;

    // Frame parser: next state, write strobe, checksum and status updates
    always_comb begin
        state_d        = state_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        load_done_d    = load_done_q;
        load_err_d     = load_err_q;
        loaded_count_d = loaded_count_q;
        acc_d          = acc_q;
        remaining_d    = remaining_q;
        match_d        = match_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d        = ST_COUNT;
                    cpu_rst_n_d    = 1'b0;
                    load_done_d    = 1'b0;
                    load_err_d     = 1'b0;
                    loaded_count_d = 5'd0;
                    acc_d          = '0;
                    mem_addr_d     = '0;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if ((in_data == '0) || (in_data > MAX_B)) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d     = ST_DATA;
                        remaining_d = in_data[4:0];
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    acc_d          = acc_q + in_data;
                    mem_we_d       = 1'b1;
                    // loaded_count doubles as the word index; COUNT bound keeps it below MAX_WORDS here
                    mem_addr_d     = loaded_count_q[ADDR_W-1:0];
                    mem_wdata_d    = in_data;
                    loaded_count_d = loaded_count_q + 5'd1;
                    remaining_d    = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    match_d = (in_data == acc_q);
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (match_q) begin
                    state_d     = ST_DONE;
                    load_done_d = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    state_d    = ST_ERR;
                    load_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cpu_rst_n_q    <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            loaded_count_q <= 5'd0;
            acc_q          <= '0;
            remaining_q    <= 5'd0;
            match_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            loaded_count_q <= loaded_count_d;
            acc_q          <= acc_d;
            remaining_q    <= remaining_d;
            match_q        <= match_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst_n;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic [4:0] loaded_count;

    int errors = 0;
    int checks = 0;

    // write log filled by the monitor
    int         wn = 0;
    logic [3:0] wr_addr [0:31];
    logic [7:0] wr_data [0:31];
    logic       prev_acc = 1'b0;
    logic [7:0] prev_data = 8'h00;

    prog_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_err     (load_err),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each write must carry the byte accepted on the immediately preceding edge
    always @(negedge clk) begin
        if (mem_we) begin
            check("we_latency", {31'd0, prev_acc}, 32'd1);
            check("we_data_src", {24'd0, mem_wdata}, {24'd0, prev_data});
            if (wn < 32) begin
                wr_addr[wn] = mem_addr;
                wr_data[wn] = mem_wdata;
            end
            wn++;
        end
        prev_acc  = in_valid && in_ready;
        prev_data = in_data;
    end

    // Present one byte, hold until it is accepted, return #1 after the transfer edge
    task automatic send(input logic [7:0] b);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [7:0] d[$]);
        check({tag, "_nwrites"}, wn, n);
        for (int i = 0; i < n && i < wn; i++) begin
            check({tag, "_addr"}, {28'd0, wr_addr[i]}, i);
            check({tag, "_data"}, {24'd0, wr_data[i]}, {24'd0, d[i]});
        end
    endtask

    initial begin
        logic [7:0] exp_d[$];
        logic [7:0] sum;

        // reset
        tick(); tick();
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_count", loaded_count, 0);
        rst_n = 1'b1;
        tick();

        // nominal frame
        wn = 0;
        send(8'hA5);
        check("nom_busy", load_busy, 1);
        send(8'h03); send(8'h12); send(8'h34); send(8'h56); send(8'h9C);
        check("nom_verify_ready", in_ready, 0);
        check("nom_verify_busy", load_busy, 1);
        check("nom_verify_cpu", cpu_rst_n, 0);
        tick();
        check("nom_done", load_done, 1);
        check("nom_cpu_rst_n", cpu_rst_n, 1);
        check("nom_count", loaded_count, 3);
        check("nom_ready_after", in_ready, 1);
        check("nom_busy_after", load_busy, 0);
        exp_d = '{8'h12, 8'h34, 8'h56};
        check_writes("nom", 3, exp_d);

        // bad checksum
        wn = 0;
        send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
        tick();
        check("badchk_err", load_err, 1);
        check("badchk_done", load_done, 0);
        check("badchk_cpu", cpu_rst_n, 0);
        check("badchk_count", loaded_count, 2);
        exp_d = '{8'h11, 8'h22};
        check_writes("badchk", 2, exp_d);

        // bad counts: zero and one over the maximum
        wn = 0;
        send(8'hA5);
        check("cnt0_err_cleared", load_err, 0);
        send(8'h00);
        check("cnt0_err", load_err, 1);
        check("cnt0_busy", load_busy, 0);
        send(8'hA5); send(8'h11);
        check("cnt17_err", load_err, 1);
        check("cnt17_count", loaded_count, 0);
        tick(); tick();
        check("badcnt_nwrites", wn, 0);

        // garbage, then a full 16-word frame with random gaps
        send(8'h00); send(8'hFF);
        check("garbage_busy", load_busy, 0);
        check("garbage_err_held", load_err, 1);
        wn = 0;
        exp_d = {};
        sum = 8'h00;
        send(8'hA5); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(8'(i));
            exp_d.push_back(8'(i));
            sum = sum + 8'(i);
        end
        check("full_sum_const", {24'd0, sum}, 32'h78);
        repeat ($urandom_range(0, 2)) tick();
        send(8'h78);
        tick();
        check("full_done", load_done, 1);
        check("full_cpu", cpu_rst_n, 1);
        check("full_count", loaded_count, 16);
        check_writes("full", 16, exp_d);

        // reload: SYNC byte used as data and as checksum
        wn = 0;
        check("reload_cpu_before", cpu_rst_n, 1);
        send(8'hA5);
        check("reload_cpu_drop", cpu_rst_n, 0);
        check("reload_done_clr", load_done, 0);
        send(8'h01); send(8'hA5); send(8'hA5);
        tick();
        check("reload_done", load_done, 1);
        check("reload_cpu", cpu_rst_n, 1);
        check("reload_count", loaded_count, 1);
        exp_d = '{8'hA5};
        check_writes("reload", 1, exp_d);

        // reset in the middle of a frame
        wn = 0;
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        tick();
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_cpu", cpu_rst_n, 0);
        check("mid_rst_busy", load_busy, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_count", loaded_count, 0);
        rst_n = 1'b1;
        send(8'h03); send(8'h04);
        tick();
        check("mid_rst_nwrites", wn, 2);
        check("mid_rst_idle_busy", load_busy, 0);
        check("mid_rst_idle_count", loaded_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the instruction-memory interface. Receives a framed byte stream over a valid/ready handshake, writes instruction bytes into the writable instruction RAM at consecutive addresses, and verifies a checksum. Holds the CPU core in reset during loading, and releases it only after a load completes and verifies. Sits between the host/debug byte source and the instruction RAM plus the CPU core's reset input.

Parameters:
ADDR_W, 4, instruction RAM address width (matches 4-bit PC)
DATA_W, 8, instruction width
SYNC_BYTE, 8'hA5, frame start marker
MAX_WORDS, 16, maximum words per frame (2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  source has a byte on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle; transfer occurs when in_valid&in_ready at rising edge
mem_we  output  1  instruction RAM write strobe, one-cycle pulse per word
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  DATA_W  RAM write data
cpu_rst_n  output  1  active-low reset to CPU core
load_busy  output  1  frame in progress (COUNT/DATA/CHECK/VERIFY)
load_done  output  1  last frame verified OK; sticky until next SYNC accepted
load_err  output  1  last frame failed; sticky until next SYNC accepted
loaded_count  output  5  words written in current or last frame (0..16)

Behaviour:
- Reset (rst_n low at clock edge): state IDLE; cpu_rst_n=0, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, load_busy=0, load_done=0, load_err=0, loaded_count=0, checksum accumulator=0. rst_n low mid-frame aborts the frame; no further writes occur.
- Frame format: SYNC_BYTE, COUNT (1..MAX_WORDS), COUNT data bytes, CHK = 8-bit modulo sum of the data bytes.
- States:
  - IDLE/DONE/ERR: in_ready=1. A byte equal to SYNC_BYTE -> COUNT, and it clears load_done, load_err, loaded_count, the accumulator, and the address counter, and drives cpu_rst_n=0. Any other byte is discarded, with no state change.
  - COUNT: a byte of 0 or >MAX_WORDS -> ERR; otherwise it is latched as the remaining-word count -> DATA.
  - DATA: each accepted byte is added to the accumulator (mod 256) and registered for writing. After the COUNT-th byte -> CHECK.
  - CHECK: the accepted byte is compared to the accumulator -> VERIFY.
  - VERIFY: lasts one cycle with in_ready=0. On match -> DONE (load_done=1, cpu_rst_n=1). On mismatch -> ERR (load_err=1, cpu_rst_n stays 0).
- Write timing: for a data byte accepted at edge t, mem_we=1, mem_addr=word index (0 upward), and mem_wdata=byte are driven for exactly the cycle after edge t. loaded_count increments in that same cycle. mem_we is 0 otherwise.
- in_valid low inserts idle cycles at any point; the state and counters hold.
- load_busy=1 in COUNT, DATA, CHECK, and VERIFY; otherwise 0.
- cpu_rst_n rises only on entry to DONE. It falls in the cycle after a SYNC byte is accepted.
- A SYNC_BYTE value received inside COUNT/DATA/CHECK is treated as ordinary data, not a restart.
- A failed frame may leave the RAM partially overwritten; the CPU stays in reset until a good frame completes.
- mem_addr never exceeds MAX_WORDS-1. The address counter does not wrap within a frame, because COUNT is bounded.

Test Plan:
- Nominal: stream A5 03 12 34 56 9C back-to-back -> three writes: (0,12), (1,34), (2,56), each one cycle after acceptance. After VERIFY: load_done=1, cpu_rst_n=1, loaded_count=3, and in_ready=0 for exactly that VERIFY cycle.
- Bad checksum: A5 02 11 22 00 -> two writes, then load_err=1, cpu_rst_n=0, load_done=0, loaded_count=2.
- Bad count: A5 00 and A5 11 (two separate frames) -> ERR immediately after the count byte, no mem_we pulses, load_err=1.
- Backpressure and garbage: 00 FF before A5 are discarded. A 16-word frame (data 00..0F, CHK 78), with in_valid randomly low between bytes -> 16 writes at addresses 0..15, load_done=1.
- Reload: after a successful frame, send A5 01 A5 A5 -> cpu_rst_n drops one cycle after the first A5. The second A5 is written to address 0 as data, and the third A5 is checked as CHK -> DONE again.
- Reset mid-frame: assert rst_n low after 2 of 4 data bytes -> all outputs return to reset values at the next edge. Following bytes are ignored until a new A5.
